// File: rtl/sdram_arbiter_if.sv
// Bundle of the two requester ports, the controller-side handshake and the idle flag.
// slave = arbiter view, master = environment view (requesters plus controller).
interface sdram_arbiter_if;
    logic        p0_valid, p0_rw, p0_ready, p0_rvalid, p0_rerr;
    logic [22:0] p0_addr;
    logic [31:0] p0_wdata, p0_rdata;
    logic        p1_valid, p1_rw, p1_ready, p1_rvalid, p1_rerr;
    logic [22:0] p1_addr;
    logic [31:0] p1_wdata, p1_rdata;
    logic        sdram_in_valid, sdram_rw, sdram_busy, sdram_out_valid;
    logic [22:0] sdram_addr;
    logic [31:0] sdram_wdata, sdram_rdata;
    logic        arb_idle;

    modport slave (
        input  p0_valid, p0_rw, p0_addr, p0_wdata,
        input  p1_valid, p1_rw, p1_addr, p1_wdata,
        input  sdram_busy, sdram_out_valid, sdram_rdata,
        output p0_ready, p0_rvalid, p0_rerr, p0_rdata,
        output p1_ready, p1_rvalid, p1_rerr, p1_rdata,
        output sdram_in_valid, sdram_rw, sdram_addr, sdram_wdata, arb_idle
    );

    modport master (
        output p0_valid, p0_rw, p0_addr, p0_wdata,
        output p1_valid, p1_rw, p1_addr, p1_wdata,
        output sdram_busy, sdram_out_valid, sdram_rdata,
        input  p0_ready, p0_rvalid, p0_rerr, p0_rdata,
        input  p1_ready, p1_rvalid, p1_rerr, p1_rdata,
        input  sdram_in_valid, sdram_rw, sdram_addr, sdram_wdata, arb_idle
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of a single-outstanding SDRAM controller,
// with a read-response timeout that returns 32'hDEADBEEF / rerr=1.
module sdram_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd256
) (
    input logic           clk,
    input logic           rst,
    sdram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, GUARD, RD_WAIT} state_t;

    state_t      state;
    logic        last_grant;
    logic        owner;
    logic [15:0] cnt;
    logic        win;

    // Tie goes to the port not granted last; otherwise the only requester wins.
    always_comb begin
        win = bus.p1_valid;
        if (bus.p0_valid && bus.p1_valid) win = ~last_grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            last_grant         <= 1'b1;
            owner              <= 1'b0;
            cnt                <= 16'd0;
            bus.sdram_in_valid <= 1'b0;
            bus.sdram_rw       <= 1'b0;
            bus.sdram_addr     <= 23'd0;
            bus.sdram_wdata    <= 32'd0;
            bus.p0_ready       <= 1'b0;
            bus.p1_ready       <= 1'b0;
            bus.p0_rvalid      <= 1'b0;
            bus.p1_rvalid      <= 1'b0;
            bus.p0_rerr        <= 1'b0;
            bus.p1_rerr        <= 1'b0;
            bus.p0_rdata       <= 32'd0;
            bus.p1_rdata       <= 32'd0;
            bus.arb_idle       <= 1'b1;
        end else begin
            bus.p0_ready  <= 1'b0;
            bus.p1_ready  <= 1'b0;
            bus.p0_rvalid <= 1'b0;
            bus.p1_rvalid <= 1'b0;
            bus.p0_rerr   <= 1'b0;
            bus.p1_rerr   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.sdram_busy && (bus.p0_valid || bus.p1_valid)) begin
                        owner              <= win;
                        bus.sdram_rw       <= win ? bus.p1_rw    : bus.p0_rw;
                        bus.sdram_addr     <= win ? bus.p1_addr  : bus.p0_addr;
                        bus.sdram_wdata    <= win ? bus.p1_wdata : bus.p0_wdata;
                        bus.sdram_in_valid <= 1'b1;
                        bus.arb_idle       <= 1'b0;
                        state              <= ISSUE;
                    end
                end
                ISSUE: begin
                    // in_valid is always high here, so !busy is the acceptance.
                    if (!bus.sdram_busy) begin
                        bus.sdram_in_valid <= 1'b0;
                        last_grant         <= owner;
                        if (owner) bus.p1_ready <= 1'b1;
                        else       bus.p0_ready <= 1'b1;
                        if (bus.sdram_rw) begin
                            state <= GUARD;
                        end else begin
                            cnt   <= 16'd0;
                            state <= RD_WAIT;
                        end
                    end
                end
                GUARD: begin
                    bus.arb_idle <= 1'b1;
                    state        <= IDLE;
                end
                RD_WAIT: begin
                    if (bus.sdram_out_valid) begin
                        if (owner) begin
                            bus.p1_rdata  <= bus.sdram_rdata;
                            bus.p1_rvalid <= 1'b1;
                        end else begin
                            bus.p0_rdata  <= bus.sdram_rdata;
                            bus.p0_rvalid <= 1'b1;
                        end
                        state <= GUARD;
                    end else if (cnt == TIMEOUT_CYCLES - 16'd1) begin
                        if (owner) begin
                            bus.p1_rdata  <= 32'hDEADBEEF;
                            bus.p1_rvalid <= 1'b1;
                            bus.p1_rerr   <= 1'b1;
                        end else begin
                            bus.p0_rdata  <= 32'hDEADBEEF;
                            bus.p0_rvalid <= 1'b1;
                            bus.p0_rerr   <= 1'b1;
                        end
                        state <= GUARD;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with TIMEOUT_CYCLES=8; checks via immediate assertions.
module tb_sdram_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    sdram_arbiter_if bus ();

    sdram_arbiter #(.TIMEOUT_CYCLES(16'd8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input bit port, input bit rw, input logic [22:0] addr, input logic [31:0] wd);
        if (port) begin
            bus.p1_valid = 1'b1; bus.p1_rw = rw; bus.p1_addr = addr; bus.p1_wdata = wd;
        end else begin
            bus.p0_valid = 1'b1; bus.p0_rw = rw; bus.p0_addr = addr; bus.p0_wdata = wd;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.p0_valid = 0; bus.p0_rw = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_valid = 0; bus.p1_rw = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
        bus.sdram_busy = 0; bus.sdram_out_valid = 0; bus.sdram_rdata = '0;
        step(); step();
        chk("rst_sdram", 64'({bus.sdram_in_valid, bus.sdram_rw, bus.sdram_addr, bus.sdram_wdata}), 64'd0);
        chk("rst_port", 64'({bus.p0_ready, bus.p1_ready, bus.p0_rvalid, bus.p1_rvalid, bus.p0_rerr, bus.p1_rerr}), 64'd0);
        chk("rst_rdata", {bus.p0_rdata, bus.p1_rdata}, 64'd0);
        rst = 1'b0;
        step();
        chk("rst_idle", 64'(bus.arb_idle), 64'd1);

        // p0 write
        req(0, 1, 23'h001234, 32'hA5A5A5A5);
        step();
        chk("wr_issue", 64'({bus.sdram_in_valid, bus.sdram_rw, bus.sdram_addr}), 64'({1'b1, 1'b1, 23'h001234}));
        chk("wr_wdata", 64'(bus.sdram_wdata), 64'hA5A5A5A5);
        chk("wr_noready_yet", 64'({bus.p0_ready, bus.arb_idle}), 64'd0);
        step();
        chk("wr_accept", 64'({bus.sdram_in_valid, bus.p0_ready, bus.p1_ready, bus.p0_rvalid}), 64'b0100);
        bus.p0_valid = 0;
        step();
        chk("wr_guard_end", 64'({bus.p0_ready, bus.p0_rvalid, bus.arb_idle}), 64'b001);

        // busy blocks selection, then busy held 10 cycles in ISSUE
        bus.sdram_busy = 1;
        req(1, 1, 23'h7ABCDE, 32'h12345678);
        step();
        chk("busy_no_select", 64'(bus.sdram_in_valid), 64'd0);
        bus.sdram_busy = 0;
        step();
        chk("busy_issue", 64'({bus.sdram_in_valid, bus.sdram_addr}), 64'({1'b1, 23'h7ABCDE}));
        bus.sdram_busy = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("busy_hold%0d", i),
                64'({bus.sdram_in_valid, bus.sdram_rw, bus.p1_ready, bus.sdram_addr, bus.sdram_wdata}),
                64'({1'b1, 1'b1, 1'b0, 23'h7ABCDE, 32'h12345678}));
        end
        bus.sdram_busy = 0;
        step();
        chk("busy_accept", 64'({bus.sdram_in_valid, bus.p1_ready, bus.p0_ready}), 64'b010);
        bus.p1_valid = 0;
        step();

        // tie from reset: p0 first
        rst = 1'b1; step(); rst = 1'b0; step();
        req(0, 0, 23'h000111, 32'd0);
        req(1, 0, 23'h000222, 32'd0);
        step();
        chk("tie1_addr", 64'({bus.sdram_in_valid, bus.sdram_rw, bus.sdram_addr}), 64'({1'b1, 1'b0, 23'h000111}));
        step();
        chk("tie1_ready", 64'({bus.p0_ready, bus.p1_ready}), 64'b10);
        bus.p0_valid = 0;
        step(); step();
        bus.sdram_out_valid = 1; bus.sdram_rdata = 32'h11111111;
        step();
        bus.sdram_out_valid = 0;
        chk("tie1_resp", 64'({bus.p0_rvalid, bus.p0_rerr, bus.p1_rvalid, bus.p0_rdata}), 64'({3'b100, 32'h11111111}));
        step(); step();
        chk("tie1_p1_next", 64'({bus.sdram_in_valid, bus.sdram_addr}), 64'({1'b1, 23'h000222}));
        step();
        chk("p1_ready", 64'({bus.p1_ready, bus.p0_ready}), 64'b10);
        bus.p1_valid = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("p1_wait%0d", i), 64'({bus.p1_rvalid, bus.p0_rvalid}), 64'd0);
        end
        bus.sdram_out_valid = 1; bus.sdram_rdata = 32'h0BADF00D;
        step();
        bus.sdram_out_valid = 0;
        chk("p1_resp", 64'({bus.p1_rvalid, bus.p1_rerr, bus.p0_rvalid, bus.p1_rdata}), 64'({3'b100, 32'h0BADF00D}));
        chk("p0_untouched", 64'(bus.p0_rdata), 64'h11111111);
        req(0, 0, 23'h000333, 32'd0);
        req(1, 0, 23'h000444, 32'd0);
        step(); step();
        chk("tie2_p0_wins", 64'({bus.sdram_in_valid, bus.sdram_addr}), 64'({1'b1, 23'h000333}));
        step();
        chk("tie2_ready", 64'({bus.p0_ready, bus.p1_ready}), 64'b10);
        bus.p0_valid = 0; bus.p1_valid = 0;
        bus.sdram_out_valid = 1; bus.sdram_rdata = 32'h33333333;
        step();
        bus.sdram_out_valid = 0;
        step();

        // stray out_valid in IDLE
        bus.sdram_out_valid = 1;
        step(); step();
        bus.sdram_out_valid = 0;
        chk("stray_idle", 64'({bus.p0_rvalid, bus.p1_rvalid, bus.arb_idle}), 64'b001);

        // timeout on p0: response exactly 8 cycles after accept
        req(0, 0, 23'h000555, 32'd0);
        step(); step();
        chk("to_ready", 64'(bus.p0_ready), 64'd1);
        bus.p0_valid = 0;
        for (int i = 1; i < 8; i++) begin
            step();
            chk($sformatf("to_wait%0d", i), 64'(bus.p0_rvalid), 64'd0);
        end
        step();
        chk("to_resp", 64'({bus.p0_rvalid, bus.p0_rerr, bus.p1_rvalid, bus.p0_rdata}), 64'({3'b110, 32'hDEADBEEF}));
        step();
        chk("to_pulse_end", 64'({bus.p0_rvalid, bus.p0_rerr, bus.arb_idle}), 64'b001);

        // out_valid coincides with timeout on p1: real data wins
        req(1, 0, 23'h000666, 32'd0);
        step(); step();
        bus.p1_valid = 0;
        for (int i = 0; i < 7; i++) step();
        bus.sdram_out_valid = 1; bus.sdram_rdata = 32'hCAFEF00D;
        step();
        bus.sdram_out_valid = 0;
        chk("coincide", 64'({bus.p1_rvalid, bus.p1_rerr, bus.p1_rdata}), 64'({2'b10, 32'hCAFEF00D}));
        step();

        // reset mid-read, then stray out_valid
        req(0, 0, 23'h000777, 32'd0);
        step(); step();
        bus.p0_valid = 0;
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        bus.sdram_out_valid = 1; bus.sdram_rdata = 32'h77777777;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst_rd_norsp%0d", i), 64'({bus.p0_rvalid, bus.p1_rvalid, bus.p0_rerr, bus.p1_rerr}), 64'd0);
        end
        bus.sdram_out_valid = 0;
        chk("rst_rd_rdata", {bus.p0_rdata, bus.p1_rdata}, 64'd0);
        chk("rst_rd_sdram", 64'({bus.sdram_in_valid, bus.sdram_rw, bus.sdram_addr, bus.sdram_wdata}), 64'd0);
        chk("rst_rd_idle", 64'(bus.arb_idle), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd256, the read-response timeout in clk cycles, counted from acceptance.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports p0_valid/p1_valid, input, 1 bit each: the requester holds a request, with address, rw and wdata stable until its ready pulse.
REQ-005 SHALL have ports p0_rw/p1_rw, input, 1 bit each: 1 = write, 0 = read.
REQ-006 SHALL have ports p0_addr/p1_addr, input, 23 bits each, and p0_wdata/p1_wdata, input, 32 bits each.
REQ-007 SHALL have ports p0_ready/p1_ready, output, 1 bit each: a one-cycle pulse when that port's request is accepted by the controller.
REQ-008 SHALL have ports p0_rvalid/p1_rvalid, output, 1 bit each, and p0_rdata/p1_rdata, output, 32 bits each: read response.
REQ-009 SHALL have ports p0_rerr/p1_rerr, output, 1 bit each: qualifies rvalid; 1 = timed-out read.
REQ-010 SHALL have controller-side outputs sdram_in_valid (1), sdram_rw (1), sdram_addr (23) and sdram_wdata (32), all registered.
REQ-011 SHALL have controller-side inputs sdram_busy (1), sdram_out_valid (1) and sdram_rdata (32).
REQ-012 SHALL have output arb_idle, 1 bit: high only in state IDLE with no request latched.

Function
REQ-013 SHALL implement states IDLE, ISSUE, GUARD and RD_WAIT.
REQ-014 IDLE: when sdram_busy=0 and any pN_valid=1, SHALL select a winner, register its rw/addr/wdata onto sdram_*, set sdram_in_valid=1 and go to ISSUE.
REQ-015 Arbitration SHALL be round-robin: with both valid, the port not granted last wins; last_grant resets to 1, so port 0 wins the first tie.
REQ-016 ISSUE: acceptance is sdram_in_valid=1 and sdram_busy=0 in the same cycle; on acceptance, SHALL pulse pN_ready for one cycle, drop sdram_in_valid next cycle and update last_grant.
REQ-017 ISSUE: while sdram_busy=1, SHALL hold sdram_in_valid and all sdram_* fields unchanged.
REQ-018 After an accepted write, SHALL go to GUARD; GUARD lasts exactly one cycle, ignores sdram_busy, then returns to IDLE.
REQ-019 After an accepted read, SHALL go to RD_WAIT, clear the 16-bit timeout counter and record the owner port.
REQ-020 RD_WAIT: on sdram_out_valid=1, SHALL register sdram_rdata to the owner's pN_rdata, pulse its pN_rvalid for one cycle with rerr=0, then go to GUARD.
REQ-021 RD_WAIT: the counter SHALL increment each cycle; when it equals TIMEOUT_CYCLES-1 with no out_valid, SHALL pulse the owner's rvalid with rdata=32'hDEADBEEF and rerr=1, then go to GUARD.
REQ-022 If out_valid and timeout coincide, out_valid SHALL win (real data, rerr=0).
REQ-023 sdram_out_valid outside RD_WAIT SHALL be ignored: no rvalid pulse on either port.
REQ-024 At most one request SHALL be outstanding; no new selection before returning to IDLE.
REQ-025 A requester that deasserts valid before ready SHALL not be protocol-compliant; once selected, the latched copy SHALL be issued regardless.
REQ-026 The non-owner port's rdata SHALL hold its previous value; rvalid/ready SHALL never pulse on both ports in the same cycle.
REQ-027 Timing: request to sdram_in_valid is 1 cycle; in_valid to pN_ready is 0 cycles after acceptance (same-edge registered pulse following accept); out_valid to rvalid is 1 cycle.

Reset
REQ-028 On rst=1 at a clock edge, SHALL enter IDLE with last_grant=1, counter=0 and owner=0.
REQ-029 On reset, SHALL drive sdram_in_valid=0, sdram_rw=0, sdram_addr=0 and sdram_wdata=0.
REQ-030 On reset, SHALL drive all pN_ready=0, pN_rvalid=0, pN_rerr=0 and pN_rdata=0.
REQ-031 On reset, arb_idle SHALL be 1 from the first cycle after rst deasserts.
REQ-032 Reset mid-read SHALL abandon the read: a later sdram_out_valid SHALL produce no response.

Verification
REQ-033 p0 write, addr 23'h001234, data 32'hA5A5A5A5, busy=0 -> sdram_in_valid for one cycle with those fields, then p0_ready one pulse, no rvalid.
REQ-034 p0 and p1 reads valid together from reset -> p0 issued first, p1 after p0's rvalid, then next tie goes to p0 again.
REQ-035 p1 read, model returns out_valid with 32'h0BADF00D 5 cycles after accept -> p1_rvalid=1, p1_rdata=32'h0BADF00D, p1_rerr=0, p0 untouched.
REQ-036 p0 read, model never answers, TIMEOUT_CYCLES=8 -> p0_rvalid with 32'hDEADBEEF and rerr=1 exactly 8 cycles after accept.
REQ-037 sdram_busy held high 10 cycles during ISSUE -> sdram_* fields stable throughout, accept on first busy=0 cycle.
REQ-038 rst asserted in RD_WAIT, then stray out_valid -> no rvalid; all outputs at reset values.
